fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC, issues a word read on the instruction memory bus, and tolerates wait states.
- Buffers fetched instructions, each tagged with its PC, in a small FIFO for decode.
- Generates the PC advance strobe (drives the PC's clk_enable) and discards in-flight or buffered fetches on a redirect flush.

Parameters:
- RESET_VECTOR, 32'hBFC00000, value of mem_address out of reset.
- DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_pc  in  32  current PC from the PC block.
- fetch_req  in  1  fetch_pc is valid and should be fetched.
- flush  in  1  redirect: discard all in-flight and buffered fetches.
- pc_advance  out  1  one-cycle strobe, combinational; PC may update this edge.
- mem_address  out  32  word address to instruction memory.
- mem_read  out  1  read request; held until mem_waitrequest low.
- mem_waitrequest  in  1  memory stall.
- mem_readdata  in  32  valid in the cycle mem_read=1 and mem_waitrequest=0.
- instr_out  out  32  head-of-buffer instruction.
- instr_pc  out  32  PC of instr_out.
- instr_valid  out  1  buffer non-empty.
- instr_ready  in  1  decode consumes head when instr_valid=1.
- fetch_fault  out  1  sticky: misaligned fetch_pc seen.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; mem_read=0; mem_address=RESET_VECTOR.
  - Buffer empty; instr_valid=0; instr_out=0; instr_pc=0.
  - discard=0; fetch_fault=0; pc_advance=0.
- FSM states: IDLE, READ.
- IDLE → READ when fetch_req=1, flush=0, count<DEPTH, and fetch_pc[1:0]==0.
  - At that edge: mem_address<=fetch_pc; mem_read<=1.
- fetch_req=1 with fetch_pc[1:0]!=0:
  - fetch_fault<=1 (stays set until reset).
  - No read is issued; state stays IDLE.
- READ, mem_waitrequest=1: hold mem_address and mem_read stable; no other effect.
- READ, mem_waitrequest=0 (completion):
  - If discard=0 and flush=0: push {mem_address, mem_readdata}; pc_advance=1 this cycle.
  - Else: drop the data; pc_advance=0.
  - Next state IDLE; mem_read<=0; discard<=0.
- Throughput: two cycles per instruction with zero wait states. The read is issued the cycle after the PC update.
- Latency: instruction visible on instr_out the cycle after completion.
- Buffer:
  - Pop when instr_valid & instr_ready.
  - Simultaneous push and pop: count unchanged; order preserved.
  - Issue is gated on count<DEPTH at issue time, so a completing read always has a free slot.
  - Push on full cannot occur; an assertion checks this.
- Flush:
  - Clears the buffer at the edge: count<=0, so instr_valid=0 next cycle.
  - Flush has priority over pop and push.
  - Flush in READ with waitrequest=1: discard<=1. The bus read is not aborted; mem_read stays high until completion, then the data is dropped.
  - Flush in IDLE: no read is issued that cycle.
- pc_advance is never asserted while flush=1.
- Widths: mem_address is the full byte address (low 2 bits always 0). count is clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Decomposition:
- Shared package cpu_pkg holds RESET_VECTOR, the fetch_state_t enum {IDLE, READ}, and typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo (parameterised DEPTH, entry type fetch_entry_t, with push/pop/flush/count).

Test Plan:
- Reset release, fetch_req=1, fetch_pc=BFC00000, waitrequest=0, readdata=24020005:
  - Read issued next cycle; pc_advance pulses.
  - Following cycle instr_valid=1, instr_out=24020005, instr_pc=BFC00000.
- Wait states: waitrequest high 3 cycles on a read:
  - mem_read and mem_address held stable for 4 cycles.
  - pc_advance only in cycle 4.
- Back-pressure: instr_ready=0, fetches at BFC00000/04/08:
  - Two entries buffered; no third read issued.
  - Raise instr_ready: pops in order, third read follows.
- Flush mid-read: flush=1 during waitrequest=1:
  - On completion the data is dropped and pc_advance stays 0.
  - instr_valid=0; next fetch uses the new fetch_pc.
- Simultaneous push and pop with count=1: count stays 1; instr_out advances to the next instruction.
- Misaligned fetch_pc=BFC00002: fetch_fault=1, mem_read stays 0; async reset mid-READ clears all outputs immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: reset vector, fetch FSM states
// and the fetch buffer entry.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  typedef enum logic {
    IDLE,
    READ
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Flush has priority over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign valid   = count != '0;
  assign full    = count == CAP;
  assign do_push = push & ~flush;
  assign do_pop  = pop & valid & ~flush;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue is gated on free space, so a full push is a design bug.
  a_no_push_full: assert property (
    @(posedge clk) disable iff (!reset) !(do_push && full)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads for the
// current PC, tolerates wait states, buffers for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_req,
  input  logic        flush,
  output logic        pc_advance,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state, state_n;
  logic [31:0]  addr_n;
  logic         read_n;
  logic         discard, discard_n;
  logic         fault_n;
  logic [CW-1:0] count;
  logic         has_room;
  logic         misaligned;
  logic         complete;
  logic         issue;
  logic         push;
  fetch_entry_t head;

  assign misaligned = fetch_pc[1:0] != 2'b00;
  assign has_room   = count < CW'(DEPTH);
  assign complete   = (state == READ) & ~mem_waitrequest;
  assign push       = complete & ~discard & ~flush;
  assign pc_advance = push;
  assign issue      = (state == IDLE) & fetch_req & ~flush
                    & has_room & ~misaligned;

  always_comb begin
    state_n   = state;
    addr_n    = mem_address;
    read_n    = mem_read;
    discard_n = discard;
    fault_n   = fetch_fault | (fetch_req & misaligned);
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_n = READ;
          addr_n  = fetch_pc;
          read_n  = 1'b1;
        end
      end
      READ: begin
        if (complete) begin
          state_n   = IDLE;
          read_n    = 1'b0;
          discard_n = 1'b0;
        end else if (flush) begin
          // The bus read cannot be aborted; drop it on completion.
          discard_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mem_address <= RESET_VECTOR;
      mem_read    <= 1'b0;
      discard     <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      mem_address <= addr_n;
      mem_read    <= read_n;
      discard     <= discard_n;
      fetch_fault <= fault_n;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{pc: mem_address, instr: mem_readdata}),
    .pop        (instr_ready),
    .flush      (flush),
    .head       (head),
    .valid      (instr_valid),
    .count      (count)
  );

  assign instr_out = head.instr;
  assign instr_pc  = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table,
// scoreboard of fetched entries, corner sequences.
module tb_fetch_unit;

  localparam logic [31:0] B = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_req;
  logic        flush;
  logic        pc_advance;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;

  logic [31:0] tb_pc;
  logic [31:0] flush_pc;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return 32'h24020005 + (a - B);
  endfunction

  assign mem_readdata = instr_of(mem_address);
  assign fetch_pc     = tb_pc;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .fetch_req       (fetch_req),
    .flush           (flush),
    .pc_advance      (pc_advance),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .fetch_fault     (fetch_fault)
  );

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // PC block model: redirect on flush, else step on pc_advance.
  always @(posedge clk or negedge reset) begin
    if (!reset)          tb_pc <= B;
    else if (flush)      tb_pc <= flush_pc;
    else if (pc_advance) tb_pc <= tb_pc + 32'd4;
  end

  // Scoreboard: expect an entry per advance, compare on pop.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (flush) sb.delete();
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_pop", instr_pc, 32'hxxxxxxxx);
        end else begin
          check("sb_pc", instr_pc, sb[0].pc);
          check("sb_instr", instr_out, sb[0].instr);
          void'(sb.pop_front());
        end
      end
      if (pc_advance) sb.push_back('{tb_pc, instr_of(tb_pc)});
    end
  end

  typedef struct {
    logic        req, wr, rdy;
    logic        e_read, e_adv, e_valid;
    logic [31:0] e_addr, e_instr, e_ipc;
  } vec_t;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt[7];
    bit found;

    vt[0] = '{1, 0, 0, 0, 0, 0, B,     0,               0};
    vt[1] = '{1, 0, 0, 1, 1, 0, B,     0,               0};
    vt[2] = '{1, 0, 0, 0, 0, 1, B,     instr_of(B),     B};
    vt[3] = '{0, 0, 0, 1, 1, 1, B + 4, instr_of(B),     B};
    vt[4] = '{0, 0, 1, 0, 0, 1, B + 4, instr_of(B),     B};
    vt[5] = '{0, 0, 1, 0, 0, 1, B + 4, instr_of(B + 4), B + 4};
    vt[6] = '{0, 0, 1, 0, 0, 0, B + 4, 0,               0};

    reset = 1'b0;
    fetch_req = 0;
    flush = 0;
    flush_pc = B;
    mem_waitrequest = 0;
    instr_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read", mem_read, 0);
    check("rst_addr", mem_address, B);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_adv", pc_advance, 0);
    next_cycle();
    reset = 1'b1;

    // Cycle table: first fetches with zero wait states.
    for (int i = 0; i < 7; i++) begin
      fetch_req = vt[i].req;
      mem_waitrequest = vt[i].wr;
      instr_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("t%0d_read", i), mem_read, vt[i].e_read);
      check($sformatf("t%0d_adv", i), pc_advance, vt[i].e_adv);
      check($sformatf("t%0d_valid", i), instr_valid, vt[i].e_valid);
      check($sformatf("t%0d_addr", i), mem_address, vt[i].e_addr);
      check($sformatf("t%0d_instr", i), instr_out, vt[i].e_instr);
      check($sformatf("t%0d_ipc", i), instr_pc, vt[i].e_ipc);
      next_cycle();
    end

    // Three wait states on the read at B+8.
    fetch_req = 1;
    mem_waitrequest = 1;
    instr_ready = 1;
    next_cycle();
    fetch_req = 0;
    for (int i = 0; i < 4; i++) begin
      mem_waitrequest = (i < 3);
      @(negedge clk);
      check($sformatf("ws%0d_read", i), mem_read, 1);
      check($sformatf("ws%0d_addr", i), mem_address, B + 8);
      check($sformatf("ws%0d_adv", i), pc_advance, (i == 3));
      next_cycle();
    end
    mem_waitrequest = 0;
    repeat (2) next_cycle();

    // Back-pressure: two entries buffered, third read held off.
    instr_ready = 0;
    fetch_req = 1;
    repeat (5) next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_read", mem_read, 0);
      check("bp_valid", instr_valid, 1);
      check("bp_head", instr_pc, B + 12);
      next_cycle();
    end
    instr_ready = 1;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (mem_read) begin
        found = 1;
        check("bp_third_addr", mem_address, B + 20);
        fetch_req = 0;
      end
      next_cycle();
    end
    if (!found) check("bp_third_timeout", 0, 1);
    fetch_req = 0;
    repeat (4) next_cycle();
    check("bp_pc", tb_pc, B + 24);

    // Simultaneous push and pop with one entry buffered.
    instr_ready = 0;
    fetch_req = 1;
    next_cycle();
    next_cycle();
    next_cycle();
    fetch_req = 0;
    instr_ready = 1;
    @(negedge clk);
    check("pp_adv", pc_advance, 1);
    check("pp_head_old", instr_pc, B + 24);
    next_cycle();
    instr_ready = 0;
    @(negedge clk);
    check("pp_valid", instr_valid, 1);
    check("pp_head_new", instr_pc, B + 28);
    check("pp_instr_new", instr_out, instr_of(B + 28));
    next_cycle();
    instr_ready = 1;
    next_cycle();
    @(negedge clk);
    check("pp_drained", instr_valid, 0);
    next_cycle();

    // Flush mid-read with one entry buffered.
    instr_ready = 0;
    fetch_req = 1;
    next_cycle();
    next_cycle();
    mem_waitrequest = 1;
    next_cycle();
    fetch_req = 0;
    flush = 1;
    flush_pc = B + 32'h200;
    @(negedge clk);
    check("fl_adv_during_flush", pc_advance, 0);
    next_cycle();
    flush = 0;
    @(negedge clk);
    check("fl_buf_cleared", instr_valid, 0);
    check("fl_read_held", mem_read, 1);
    next_cycle();
    mem_waitrequest = 0;
    @(negedge clk);
    check("fl_drop_adv", pc_advance, 0);
    check("fl_drop_addr", mem_address, B + 36);
    next_cycle();
    @(negedge clk);
    check("fl_idle_read", mem_read, 0);
    check("fl_idle_valid", instr_valid, 0);
    fetch_req = 1;
    next_cycle();
    fetch_req = 0;
    instr_ready = 1;
    @(negedge clk);
    check("fl_new_addr", mem_address, B + 32'h200);
    check("fl_new_adv", pc_advance, 1);
    next_cycle();
    @(negedge clk);
    check("fl_new_valid", instr_valid, 1);
    check("fl_new_ipc", instr_pc, B + 32'h200);
    next_cycle();

    // Misaligned PC sets the sticky fault and issues nothing.
    flush = 1;
    flush_pc = B + 2;
    next_cycle();
    flush = 0;
    fetch_req = 1;
    @(negedge clk);
    check("mis_fault_pre", fetch_fault, 0);
    check("mis_read0", mem_read, 0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mis_fault", fetch_fault, 1);
      check("mis_no_read", mem_read, 0);
      next_cycle();
    end

    // Async reset in the middle of a stalled read.
    fetch_req = 0;
    flush = 1;
    flush_pc = B + 32'h100;
    next_cycle();
    flush = 0;
    instr_ready = 0;
    fetch_req = 1;
    next_cycle();
    next_cycle();
    mem_waitrequest = 1;
    next_cycle();
    fetch_req = 0;
    @(negedge clk);
    check("ar_pre_read", mem_read, 1);
    check("ar_pre_valid", instr_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_read", mem_read, 0);
    check("ar_addr", mem_address, B);
    check("ar_valid", instr_valid, 0);
    check("ar_instr", instr_out, 0);
    check("ar_ipc", instr_pc, 0);
    check("ar_fault", fetch_fault, 0);
    check("ar_adv", pc_advance, 0);
    next_cycle();
    reset = 1'b1;
    mem_waitrequest = 0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
